// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue controller for a purely combinational ALU whose outputs need several
// cycles to settle. A request (operands + command) is registered onto the ALU
// inputs, held stable for SETTLE cycles, and then the ALU result and flags are
// captured into an output register guarded by a valid/ready handshake. A new
// request may be accepted on the same edge that the previous result is
// consumed, so a fully streaming source sees one operation every SETTLE+1
// cycles.
//
// Parameters
//   WIDTH   operand/result width (must match the downstream ALU)
//   SETTLE  cycles the ALU inputs are held before capture, 1..255
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid/in_ready              upstream request handshake
//   in_a, in_b, in_cmd             request operands and ALU command
//   alu_a, alu_b, alu_cmd          registered operands/command to the ALU
//   alu_result, alu_carryout,
//   alu_zero, alu_overflow         ALU outputs (sampled at capture)
//   out_valid/out_ready            downstream result handshake
//   out_result, out_carryout,
//   out_zero, out_overflow         captured ALU outputs
//   busy                           an operation is in flight
//   op_count                       completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_cmd,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carryout,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Counter reload value: an accept at edge E captures at edge E+SETTLE.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       ready_int;
  logic       accept;
  logic       capture;
  logic       out_hs;

  // ---------------------------------------------------------------------------
  // Next-state / handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    ready_int = 1'b0;
    capture   = 1'b0;
    out_hs    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        ready_int = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt == 8'd0) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_HOLD: begin
        // A new request is only admitted when the held result leaves on the
        // same edge, so the output register is never overwritten unread.
        ready_int = out_ready;
        out_hs    = out_ready;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    accept = in_valid & ready_int;
    if (accept) begin
      state_nxt = ST_SETTLE;
      cnt_nxt   = SETTLE_LOAD;
    end
  end

  // in_ready must read 0 while reset is held even though state is IDLE.
  assign in_ready = ready_int & ~reset;
  assign busy     = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU input registers: only an accept changes them, so they stay frozen for
  // the whole settle window and while the result is held.
  // ---------------------------------------------------------------------------
  // NOTE: these are ordinary flops with a defined reset value; the abandoned
  // operation's operands must not linger after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= 3'd0;
    end else if (accept) begin
      alu_a   <= in_a;
      alu_b   <= in_b;
      alu_cmd <= in_cmd;
    end
  end

  // ---------------------------------------------------------------------------
  // Output capture: values persist after the handshake until the next capture.
  // Flags are passed through exactly as the ALU presents them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_result   <= '0;
      out_carryout <= 1'b0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
    end else if (capture) begin
      out_result   <= alu_result;
      out_carryout <= alu_carryout;
      out_zero     <= alu_zero;
      out_overflow <= alu_overflow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Free-running handshake counter; natural 16-bit wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count <= 16'd0;
    end else if (out_hs) begin
      op_count <= op_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Scoreboard bench for alu_issue_ctrl. A behavioural ALU drives the DUT's ALU
// inputs. The driver keeps a transaction-level model (operation in flight,
// accept time, handshake count) and pushes the expected result and capture
// cycle on every accept; a separate monitor pops and compares whenever a new
// result appears. A second instance with SETTLE=1 exercises op_count wrap.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int S = 8;

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        o;
  } alu_out_t;

  typedef struct {
    alu_out_t res;
    longint   cyc;
  } exp_t;

  // ---------------------------------------------------------------------------
  // Main DUT signals
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_cmd;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_cmd;
  logic [31:0] alu_result;
  logic        alu_carryout, alu_zero, alu_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_carryout, out_zero, out_overflow;
  logic        busy;
  logic [15:0] op_count;

  // Wrap-test instance signals
  logic        w_reset, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_alu_a, w_alu_b, w_out_result;
  logic [2:0]  w_alu_cmd;
  logic        w_out_carryout, w_out_zero, w_out_overflow, w_busy;
  logic [15:0] w_op_count;

  // Counters and model state
  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cyc      = 0;
  exp_t        sb[$];
  bit          outstanding = 1'b0;
  longint      acc_cyc     = 0;
  logic [15:0] exp_ops     = 16'd0;
  bit          last_acc;
  longint      last_acc_cyc;
  bit          wrap_fin = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Behavioural ALU (also the reference for expected results)
  // ---------------------------------------------------------------------------
  function automatic alu_out_t alu_model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] cmd);
    alu_out_t   o;
    logic [32:0] sum;
    o = '0;
    case (cmd)
      3'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        o.r = sum[31:0];
        o.c = sum[32];
        o.o = (a[31] == b[31]) && (o.r[31] != a[31]);
      end
      3'd1: begin
        o.r = a - b;
        o.c = (a >= b);
        o.o = (a[31] != b[31]) && (o.r[31] != a[31]);
      end
      3'd2:    o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    o.r = a ^ b;
      3'd4:    o.r = ~(a & b);
      3'd5:    o.r = a & b;
      3'd6:    o.r = ~(a | b);
      default: o.r = a | b;
    endcase
    o.z = (o.r == 32'd0);
    return o;
  endfunction

  alu_out_t alu_now;
  always_comb begin
    alu_now      = alu_model(alu_a, alu_b, alu_cmd);
    alu_result   = alu_now.r;
    alu_carryout = alu_now.c;
    alu_zero     = alu_now.z;
    alu_overflow = alu_now.o;
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  alu_issue_ctrl #(.WIDTH(32), .SETTLE(S)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmd(in_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carryout(out_carryout),
    .out_zero(out_zero), .out_overflow(out_overflow),
    .busy(busy), .op_count(op_count)
  );

  alu_issue_ctrl #(.WIDTH(32), .SETTLE(1)) dut_wrap (
    .clk(clk), .reset(w_reset),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(32'd1), .in_b(32'd2), .in_cmd(3'd0),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_cmd(w_alu_cmd),
    .alu_result(32'd0), .alu_carryout(1'b0),
    .alu_zero(1'b0), .alu_overflow(1'b0),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_result(w_out_result), .out_carryout(w_out_carryout),
    .out_zero(w_out_zero), .out_overflow(w_out_overflow),
    .busy(w_busy), .op_count(w_op_count)
  );

  // ---------------------------------------------------------------------------
  // Check helper
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one call per clock cycle. Inputs change on the falling edge; the
  // model then decides what the coming rising edge must do.
  // ---------------------------------------------------------------------------
  task automatic drive_cycle(input logic v, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] cmd, input logic r);
    bit   in_hold, exp_rdy, hs, acc;
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_cmd    = cmd;
    out_ready = r;
    #1;
    // The result of an operation accepted at edge A is available from edge A+S.
    in_hold = outstanding && (cyc >= acc_cyc + S);
    exp_rdy = !outstanding || (in_hold && r);
    hs      = in_hold && r;
    acc     = v && exp_rdy;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(outstanding));
    if (hs) begin
      exp_ops++;
      outstanding = 1'b0;
    end
    if (acc) begin
      e.res = alu_model(a, b, cmd);
      e.cyc = cyc + 1 + S;
      sb.push_back(e);
      outstanding = 1'b1;
      acc_cyc     = cyc + 1;
    end
    last_acc     = acc;
    last_acc_cyc = cyc + 1;
  endtask

  task automatic idle_cycle(input logic r);
    drive_cycle(1'b0, $urandom, $urandom, 3'($urandom), r);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd);
    drive_cycle(1'b1, a, b, cmd, 1'b0);
    check("issue_accept", 64'(last_acc), 64'd1);
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      idle_cycle(1'b0);
    end
    check("wait_valid", 64'(seen), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && outstanding; i++) idle_cycle(1'b1);
    check("drain_done", 64'(outstanding), 64'd0);
    idle_cycle(1'b0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    outstanding = 1'b0;
    exp_ops     = 16'd0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_cmd", 64'(alu_cmd), 64'd0);
    check("rst_out", 64'({out_result, out_carryout, out_zero, out_overflow}), 64'd0);
    repeat (cycles) @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: just after each rising edge, compare any newly presented result
  // and verify held results do not move.
  // ---------------------------------------------------------------------------
  initial begin
    bit       prev_valid = 1'b0;
    logic [34:0] held    = '0;
    exp_t     e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid && !prev_valid) begin
          check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("out_result", 64'(out_result), 64'(e.res.r));
            check("out_flags", 64'({out_carryout, out_zero, out_overflow}),
                  64'({e.res.c, e.res.z, e.res.o}));
            check("capture_cycle", 64'(cyc), 64'(e.cyc));
          end
          held = {out_result, out_carryout, out_zero, out_overflow};
        end else if (out_valid) begin
          check("hold_stable", 64'({out_result, out_carryout, out_zero, out_overflow}),
                64'(held));
        end
        check("op_count", 64'(op_count), 64'(exp_ops));
        prev_valid = out_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Wrap test on the SETTLE=1 instance: streams continuously and checks the
  // counter at the 65535th and 65536th handshakes.
  // ---------------------------------------------------------------------------
  initial begin
    int hs   = 0;
    bit done = 1'b0;
    w_reset     = 1'b1;
    w_in_valid  = 1'b0;
    w_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    w_reset     = 1'b0;
    w_in_valid  = 1'b1;
    w_out_ready = 1'b1;
    for (int i = 0; i < 140000 && !done; i++) begin
      @(negedge clk);
      if (hs == 65535) check("wrap_ffff", 64'(w_op_count), 64'h0000_ffff);
      if (hs == 65536) begin
        check("wrap_zero", 64'(w_op_count), 64'd0);
        done = 1'b1;
      end
      if (w_out_valid) hs++;
    end
    check("wrap_done", 64'(done), 64'd1);
    wrap_fin = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a2;
    longint      prev_acc;
    int          n_acc;
    logic [15:0] ops_before;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cmd = '0;
    do_reset(2);

    // ADD 5+3, latency S checked by the monitor
    issue(32'd5, 32'd3, 3'd0);
    wait_valid();
    check("add_result", 64'(out_result), 64'd8);
    check("add_flags", 64'({out_carryout, out_zero, out_overflow}), 64'd0);
    idle_cycle(1'b1);

    // SUB without and with signed overflow
    issue(32'd3, 32'd5, 3'd1);
    wait_valid();
    check("sub_neg_result", 64'(out_result), 64'hffff_fffe);
    check("sub_neg_ovf", 64'(out_overflow), 64'd0);
    idle_cycle(1'b1);
    issue(32'h8000_0000, 32'd1, 3'd1);
    wait_valid();
    check("sub_ovf_result", 64'(out_result), 64'h7fff_ffff);
    check("sub_ovf_ovf", 64'(out_overflow), 64'd1);
    idle_cycle(1'b1);

    // Backpressure in HOLD with a pending request
    issue(32'hdead_beef, 32'h1234_5678, 3'd3);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, $urandom, $urandom, 3'd4, 1'b0);
      check("bp_no_accept", 64'(last_acc), 64'd0);
      check("bp_alu_a", 64'(alu_a), 64'hdead_beef);
    end
    a2 = 32'h0bad_f00d;
    drive_cycle(1'b1, a2, 32'h0000_00ff, 3'd5, 1'b1);
    check("bp_release_accept", 64'(last_acc), 64'd1);
    idle_cycle(1'b0);
    check("bp_alu_a_loaded", 64'(alu_a), 64'(a2));
    wait_valid();
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // Back-to-back stream of 4 requests
    ops_before = exp_ops;
    n_acc = 0;
    prev_acc = 0;
    for (int i = 0; i < 100 && n_acc < 4; i++) begin
      drive_cycle(1'b1, $urandom, $urandom, 3'($urandom), 1'b1);
      if (last_acc) begin
        if (n_acc > 0) check("b2b_spacing", 64'(last_acc_cyc - prev_acc), 64'(S + 1));
        prev_acc = last_acc_cyc;
        n_acc++;
      end
    end
    check("b2b_accepts", 64'(n_acc), 64'd4);
    drain();
    check("b2b_op_count", 64'(op_count), 64'(ops_before + 16'd4));

    // Reset in the middle of SETTLE abandons the operation
    issue(32'd7, 32'd9, 3'd0);
    repeat (3) idle_cycle(1'b1);
    do_reset(2);
    issue(32'd1, 32'd1, 3'd0);
    wait_valid();
    check("post_rst_add", 64'(out_result), 64'd2);
    idle_cycle(1'b1);

    // Randomised traffic, all commands, random backpressure
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom),
                  1'($urandom_range(0, 3) != 0));
    end
    drain();
    check("sb_drained", 64'(sb.size()), 64'd0);

    wait (wrap_fin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; shall match the downstream ALU width.
REQ-002 Parameter SETTLE, default 8, number of clock cycles operands are held stable before ALU outputs are captured; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_a, in_b  input  WIDTH each  operands A and B.
REQ-008 in_cmd  input  3  ALU command (0 ADD, 1 SUB, 2 SLT, 3 XOR, 4 NAND, 5 AND, 6 NOR, 7 OR).
REQ-009 alu_a, alu_b  output  WIDTH each  registered operands driven to the ALU.
REQ-010 alu_cmd  output  3  registered command driven to the ALU.
REQ-011 alu_result  input  WIDTH  ALU result.
REQ-012 alu_carryout, alu_zero, alu_overflow  input  1 each  ALU flags.
REQ-013 out_valid  output  1  captured result available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  WIDTH; out_carryout, out_zero, out_overflow  output  1 each  captured ALU outputs.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 op_count  output  16  number of completed output handshakes.

Function
REQ-018 FSM states: IDLE, SETTLE, HOLD.
REQ-019 in_ready shall be 1 in IDLE, equal out_ready in HOLD, and 0 in SETTLE.
REQ-020 Accept = in_valid & in_ready at a rising edge; on accept, alu_a/alu_b/alu_cmd load in_a/in_b/in_cmd, the settle counter loads SETTLE-1, and the next state is SETTLE.
REQ-021 alu_a, alu_b and alu_cmd shall change only on accept; they are held constant in SETTLE and HOLD.
REQ-022 In SETTLE, the counter decrements each edge; on the edge where the counter equals 0, out_* shall capture alu_* inputs, out_valid shall go to 1, and the next state is HOLD.
REQ-023 Latency: for an accept at edge E, the capture occurs at edge E+SETTLE, and out_valid is high from that edge.
REQ-024 In HOLD, out_valid and out_* shall stay stable until out_ready=1 at an edge (output handshake).
REQ-025 On an output handshake without a simultaneous accept, out_valid shall go to 0 and the next state is IDLE.
REQ-026 On an output handshake with a simultaneous accept (in_valid=1), the new request is loaded per REQ-020, out_valid goes to 0, and the next state is SETTLE; no bubble cycle is inserted.
REQ-027 out_* values shall retain the last captured value while out_valid=0.
REQ-028 op_count shall increment by 1 on every output handshake and wrap from 0xFFFF to 0x0000.
REQ-029 in_a, in_b and in_cmd shall be ignored when no accept occurs; all 8 in_cmd codes are legal and are passed through unmodified.
REQ-030 Flags are captured as presented by the ALU; no masking or recomputation is performed.

Reset
REQ-031 While reset=1, regardless of clk: state=IDLE, counter=0, alu_a=alu_b=0, alu_cmd=0, out_valid=0, out_result=0, all out flags=0, op_count=0, busy=0, in_ready=0.
REQ-032 After reset deasserts, in_ready=1 from the first cycle.
REQ-033 Reset asserted during SETTLE or HOLD shall abandon the in-flight operation with no output handshake and no op_count change.

Verification
REQ-034 SETTLE=8, ADD a=5 b=3 -> out_valid rises exactly 8 edges after accept; out_result=8, out_carryout=0, out_zero=0, out_overflow=0.
REQ-035 SUB a=3 b=5 -> out_result=0xFFFFFFFE, out_overflow=0; SUB a=0x80000000 b=1 -> out_result=0x7FFFFFFF, out_overflow=1.
REQ-036 out_ready held 0 for 5 cycles in HOLD, with in_valid=1 and changing in_a -> out_* and alu_a are stable, in_ready=0, and there is no accept; out_ready=1 -> handshake completes and the pending request is accepted on the same edge.
REQ-037 Back-to-back: 4 requests with out_ready=1 continuously -> one accept every SETTLE+1 cycles, op_count=4, and busy stays high between the operations.
REQ-038 Reset pulsed 3 cycles after accept -> out_valid=0, op_count=0, and in_ready=1 on the first cycle after reset release; a subsequent ADD 1+1 returns 2.
REQ-039 op_count forced to 0xFFFF via 65535 handshakes (SETTLE=1), then one more handshake -> op_count=0x0000.
